eth_dut: RTL and testbench
==========================

# eth_dut

Store-and-forward Ethernet loopback block. It accepts one frame as a byte stream on a valid/ready receive port and buffers it internally. Once the frame ends, it replays the identical byte sequence on a valid/ready transmit port. It sits between the bench's packet BFM/driver (`eth_intf` receive side) and the monitor/reference model (transmit side).

## Interface
Parameters:
- DATA_W, 8, byte width of data_in/data_out
- MAX_LEN, 1518, maximum frame length in bytes (buffer depth)

Ports:
- clk, input, 1, single clock; all logic on posedge
- rst, input, 1, reset; asynchronous, active-high
- data_in, input, DATA_W, receive byte
- valid_in, input, 1, receive byte valid; held high for the whole frame
- ready_out, output, 1, DUT can accept a receive byte
- data_out, output, DATA_W, transmit byte
- valid_out, output, 1, transmit byte valid
- ready_in, input, 1, downstream accepts the transmit byte

## Operation
- Transfer rules:
  - Receive byte moves on a posedge with valid_in && ready_out.
  - Transmit byte moves on a posedge with valid_out && ready_in.
- Frame delimiting: the frame is the contiguous run of accepted bytes while valid_in stays high. valid_in sampled low in RX marks end of frame. No intra-frame gaps are supported.
- FSM states: IDLE, RX, TX.
  - IDLE: ready_out=0, valid_out=0. valid_in=1 → RX; ready_out=1 from the next cycle.
  - RX: write each accepted byte to buffer[wr_cnt], wr_cnt++.
    - valid_in=0 with wr_cnt≥1 → ready_out=0, latch len=wr_cnt, go TX.
    - Byte number MAX_LEN accepted → frame truncated. ready_out=0 next cycle; remaining input bytes stay unaccepted until TX completes. len=MAX_LEN, go TX.
  - TX: valid_out=1, data_out=buffer[rd_cnt]. On each handshake rd_cnt++. After byte len-1 is accepted: valid_out=0, counters cleared, go IDLE.
- Content: output bytes equal input bytes in order, unmodified (no MAC swap, no CRC check or regeneration).
- While in TX, ready_out=0. valid_in may be high; the input is simply back-pressured.
- Only one frame is buffered at a time; the next frame starts only after TX returns to IDLE.

## Timing
- Reset: ready_out=0, valid_out=0, data_out=0, state IDLE, wr_cnt=rd_cnt=len=0. Takes effect immediately (async) and is released synchronously. Reset during RX or TX discards the frame; no partial output afterwards.
- ready_out is registered:
  - It rises exactly 1 cycle after valid_in is first sampled high in IDLE, which satisfies the rule that ready rises within 0–2 cycles of valid.
  - It stays high every RX cycle until the end or truncation condition.
- Loopback latency:
  - valid_in sampled low at edge N ends the frame.
  - valid_out=1 with data_out=byte0 is visible after edge N+1. This requires a registered read with prefetch.
- data_out and valid_out are registered.
  - data_out holds stable while valid_out && !ready_in.
  - The next byte appears the cycle after each handshake, so full throughput is 1 byte/cycle with ready_in held high.
- valid_out never drops before its byte is accepted.
- Frame length range is 1..MAX_LEN. Length 0 is impossible because RX is entered only when valid_in=1 and ready_out then rises.
- Counters are ceil(log2(MAX_LEN+1)) bits wide and never wrap.

## Test plan
- Reset check: assert rst for 10 ns at t=0 → all outputs 0. After release with valid_in=0 for 10 cycles → ready_out and valid_out remain 0.
- Single 64-byte frame (bytes 0x00..0x3F), ready_in=1:
  - ready_out rises 1 cycle after valid_in.
  - 64 bytes are accepted.
  - valid_out rises 1 cycle after the end of frame.
  - data_out = 0x00..0x3F on 64 consecutive cycles, then valid_out=0.
- Backpressure: 16-byte frame with ready_in toggling 1,0,0,1,… → each byte is held until accepted; the output sequence is exact with no duplicates or drops; valid_out=0 after byte 15.
- Back-to-back: frame A (10 bytes, 0xA0..0xA9), then valid_in raised for frame B (5 bytes, 0xB0..0xB4) during A's TX → ready_out=0 until A completes. B is then accepted and echoed intact.
- Truncation: 1520-byte stream → exactly 1518 bytes accepted and echoed. ready_out=0 after byte 1518.
- Reset mid-RX after 20 bytes → outputs cleared, no valid_out. A subsequent 8-byte frame is echoed correctly.

Source files
------------

// File: rtl/eth_dut.sv
// Store-and-forward Ethernet loopback: buffers one received frame, then replays
// the identical byte sequence on the transmit handshake.
module eth_dut #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 1518
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready_in
);
   localparam int CNT_W  = $clog2(MAX_LEN + 1);
   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

   typedef enum logic [1:0] {IDLE, RX, TX} state_t;

   state_t            state, state_nxt;
   logic              ready_nxt;
   logic              rx_end;
   logic [CNT_W-1:0]  wr_cnt, rd_cnt, len;
   logic [DATA_W-1:0] buffer [MAX_LEN];
   logic              rx_fire, tx_fire, tx_load, tx_done;

   assign rx_fire = valid_in && ready_out;
   assign tx_fire = valid_out && ready_in;
   // rd_cnt counts bytes already prefetched into data_out, so the last byte
   // is in flight once rd_cnt reaches len.
   assign tx_load = (state == TX) && (rd_cnt < len) && (!valid_out || ready_in);
   assign tx_done = tx_fire && (rd_cnt == len);

   always_comb begin
      state_nxt = state;
      ready_nxt = ready_out;
      rx_end    = 1'b0;
      case (state)
         IDLE: begin
            if (valid_in) begin
               state_nxt = RX;
               ready_nxt = 1'b1;
            end
         end
         RX: begin
            if (rx_fire && (wr_cnt == LAST_IDX)) begin
               state_nxt = TX;
               ready_nxt = 1'b0;
               rx_end    = 1'b1;
            end else if (!valid_in) begin
               ready_nxt = 1'b0;
               rx_end    = (wr_cnt != '0);
               state_nxt = (wr_cnt != '0) ? TX : IDLE;
            end
         end
         TX: begin
            if (tx_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            ready_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ready_out <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         len       <= '0;
      end else begin
         state     <= state_nxt;
         ready_out <= ready_nxt;
         if (rx_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (rx_end) begin
            len <= rx_fire ? wr_cnt + 1'b1 : wr_cnt;
         end
         if (tx_load) begin
            data_out  <= buffer[rd_cnt[ADDR_W-1:0]];
            valid_out <= 1'b1;
            rd_cnt    <= rd_cnt + 1'b1;
         end else if (tx_fire) begin
            valid_out <= 1'b0;
         end
         if (tx_done) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            len    <= '0;
         end
      end
   end

   // Frame storage has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (rx_fire) begin
         buffer[wr_cnt[ADDR_W-1:0]] <= data_in;
      end
   end
endmodule

// File: tb/tb_eth_dut.sv
// Directed testbench for eth_dut: reset, single frame, backpressure,
// back-to-back frames, truncation and reset during receive.
module tb_eth_dut;
   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 1518;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] data_in;
   logic              valid_in;
   logic              ready_out;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              ready_in;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] out_q[$];

   eth_dut #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in)
   );

   always #5 clk = ~clk;

   // Inputs settle 1 ns after posedge, so the negedge view predicts the handshake.
   always @(negedge clk) begin
      if (!rst && valid_out && ready_in) out_q.push_back(data_out);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic drive_frame(input int n, output int stalls_first,
                              output int out_at_first, output bit ok);
      int i;
      int cyc;
      i = 0;
      cyc = 0;
      stalls_first = 0;
      out_at_first = -1;
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = tx_q[0];
      while (i < n && cyc < 4000) begin
         @(negedge clk);
         if (ready_out) begin
            if (i == 0) out_at_first = out_q.size();
            i++;
         end else if (i == 0) begin
            stalls_first++;
         end
         @(posedge clk); #1;
         cyc++;
         if (i < n) data_in = tx_q[i];
      end
      valid_in = 1'b0;
      data_in  = '0;
      ok = (i == n);
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      int c;
      c = 0;
      while (out_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (out_q.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b1;
      data_in = '0;
      #8;
      tests_run++;
      if (ready_out !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: ready=%b valid=%b data=%h, expected 0/0/00",
                  ready_out, valid_out, data_out);
      end
      #2 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests_run++;
         if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_quiet cycle %0d: ready=%b valid=%b, expected 0/0",
                     c, ready_out, valid_out);
         end
      end
   endtask

   task automatic test_single_frame();
      int stalls, oaf, lat;
      bit ok;
      out_q.delete();
      tx_q.delete();
      for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
      ready_in = 1'b1;
      drive_frame(64, stalls, oaf, ok);
      tests_run++;
      if (ok !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL single_accept: all 64 accepted=%b, expected 1", ok);
      end
      tests_run++;
      if (stalls != 1) begin
         tests_failed++;
         $display("[TB] FAIL single_ready_rise: ready after %0d cycles, expected 1", stalls);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!valid_out && lat < 10);
      tests_run++;
      if (lat != 3) begin
         tests_failed++;
         $display("[TB] FAIL single_latency: valid_out seen at negedge %0d, expected 3", lat);
      end
      for (int i = 0; i < 64; i++) begin
         tests_run++;
         if (valid_out !== 1'b1 || data_out !== 8'(i)) begin
            tests_failed++;
            $display("[TB] FAIL single_stream byte %0d: valid=%b data=%h, expected 1/%h",
                     i, valid_out, data_out, 8'(i));
         end
         @(negedge clk);
      end
      tests_run++;
      if (valid_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_end: valid_out=%b, expected 0", valid_out);
      end
      tests_run++;
      if (out_q.size() != 64) begin
         tests_failed++;
         $display("[TB] FAIL single_count: %0d bytes out, expected 64", out_q.size());
      end
   endtask

   task automatic test_backpressure();
      int stalls, oaf, got, c, bad;
      bit ok, hold;
      logic [7:0] held;
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      out_q.delete();
      tx_q.delete();
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         tx_q.push_back(8'(8'h50 + i));
         exp_q.push_back(8'(8'h50 + i));
      end
      ready_in = 1'b1;
      drive_frame(16, stalls, oaf, ok);
      got = 0;
      c = 0;
      hold = 1'b0;
      held = '0;
      while (got < 16 && c < 300) begin
         @(posedge clk); #1;
         ready_in = pat[c % 4];
         c++;
         @(negedge clk);
         if (hold) begin
            tests_run++;
            if (valid_out !== 1'b1 || data_out !== held) begin
               tests_failed++;
               $display("[TB] FAIL bp_hold: valid=%b data=%h, expected 1/%h",
                        valid_out, data_out, held);
            end
         end
         hold = valid_out && !ready_in;
         held = data_out;
         if (valid_out && ready_in) got++;
      end
      tests_run++;
      if (got != 16) begin
         tests_failed++;
         $display("[TB] FAIL bp_count: %0d bytes transferred, expected 16", got);
      end
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bp_end: valid_out=%b, expected 0", valid_out);
      end
      ready_in = 1'b1;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
      end
      tests_run++;
      if (bad != 0 || out_q.size() != 16) begin
         tests_failed++;
         $display("[TB] FAIL bp_data: %0d bytes out with %0d wrong, expected 16 with 0 wrong",
                  out_q.size(), bad);
      end
   endtask

   task automatic test_back_to_back();
      int stalls, oaf, c, bad;
      bit ok;
      out_q.delete();
      tx_q.delete();
      exp_q.delete();
      ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tx_q.push_back(8'(8'hA0 + i));
         exp_q.push_back(8'(8'hA0 + i));
      end
      drive_frame(10, stalls, oaf, ok);
      c = 0;
      while (!valid_out && c < 20) begin
         @(negedge clk);
         c++;
      end
      tests_run++;
      if (valid_out !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_a_tx: valid_out=%b, expected 1", valid_out);
      end
      tx_q.delete();
      for (int i = 0; i < 5; i++) begin
         tx_q.push_back(8'(8'hB0 + i));
         exp_q.push_back(8'(8'hB0 + i));
      end
      drive_frame(5, stalls, oaf, ok);
      tests_run++;
      if (oaf != 10) begin
         tests_failed++;
         $display("[TB] FAIL b2b_blocked: B accepted after %0d A bytes out, expected 10", oaf);
      end
      wait_out(15, 200, ok);
      tests_run++;
      if (ok !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_timeout: %0d bytes out, expected 15", out_q.size());
      end
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_data: %0d wrong bytes, expected 0", bad);
      end
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_end: valid_out=%b, expected 0", valid_out);
      end
   endtask

   task automatic test_truncation();
      int i, stall_run, cyc, bad;
      bit ok;
      out_q.delete();
      tx_q.delete();
      exp_q.delete();
      ready_in = 1'b1;
      for (int k = 0; k < 1520; k++) tx_q.push_back(8'(k * 7 + 3));
      for (int k = 0; k < MAX_LEN; k++) exp_q.push_back(8'(k * 7 + 3));
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in = tx_q[0];
      i = 0;
      stall_run = 0;
      cyc = 0;
      while (i < 1520 && stall_run < 16 && cyc < 4000) begin
         @(negedge clk);
         if (ready_out) begin
            i++;
            stall_run = 0;
         end else if (i > 0) begin
            stall_run++;
         end
         @(posedge clk); #1;
         cyc++;
         if (i < 1520) data_in = tx_q[i];
      end
      valid_in = 1'b0;
      data_in = '0;
      tests_run++;
      if (i != MAX_LEN) begin
         tests_failed++;
         $display("[TB] FAIL trunc_accept: %0d bytes accepted, expected %0d", i, MAX_LEN);
      end
      wait_out(MAX_LEN, 2000, ok);
      tests_run++;
      if (ok !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL trunc_timeout: %0d bytes out, expected %0d", out_q.size(), MAX_LEN);
      end
      bad = 0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (k >= out_q.size() || out_q[k] !== exp_q[k]) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL trunc_data: %0d wrong bytes, expected 0", bad);
      end
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b0 || out_q.size() != MAX_LEN) begin
         tests_failed++;
         $display("[TB] FAIL trunc_end: valid=%b count=%0d, expected 0/%0d",
                  valid_out, out_q.size(), MAX_LEN);
      end
   endtask

   task automatic test_reset_mid_rx();
      int stalls, oaf, bad;
      bit ok;
      out_q.delete();
      tx_q.delete();
      exp_q.delete();
      ready_in = 1'b1;
      for (int i = 0; i < 20; i++) tx_q.push_back(8'(8'hC0 + i));
      drive_frame(20, stalls, oaf, ok);
      rst = 1'b1;
      #1;
      tests_run++;
      if (ready_out !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL midrx_reset: ready=%b valid=%b data=%h, expected 0/0/00",
                  ready_out, valid_out, data_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests_run++;
         if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrx_no_output cycle %0d: valid_out=%b, expected 0", c, valid_out);
         end
      end
      tests_run++;
      if (out_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL midrx_discard: %0d bytes out, expected 0", out_q.size());
      end
      tx_q.delete();
      for (int i = 0; i < 8; i++) begin
         tx_q.push_back(8'(8'h3C ^ (i * 17)));
         exp_q.push_back(8'(8'h3C ^ (i * 17)));
      end
      drive_frame(8, stalls, oaf, ok);
      wait_out(8, 100, ok);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
      end
      tests_run++;
      if (ok !== 1'b1 || bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL midrx_next_frame: %0d bytes out with %0d wrong, expected 8 with 0 wrong",
                  out_q.size(), bad);
      end
      @(negedge clk);
      tests_run++;
      if (valid_out !== 1'b0 || out_q.size() != 8) begin
         tests_failed++;
         $display("[TB] FAIL midrx_end: valid=%b count=%0d, expected 0/8", valid_out, out_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_truncation();
      test_reset_mid_rx();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
